// File: rtl/register_file_scan_mp_if.sv
// Bus interface for register_file_scan_mp: read/write ports and the scan handshake.
// The master modport drives addresses, write data and scan controls; the slave modport is the register file.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

interface register_file_scan_mp_if #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned WIDTH    = `WORD_LENGTH,
  parameter int unsigned RD_PORTS = 3,
  parameter int unsigned WR_PORTS = 2
);
  localparam int unsigned AW = $clog2(SIZE);

  logic [RD_PORTS*AW-1:0]    readAddr;
  logic [RD_PORTS*WIDTH-1:0] readData;
  logic [WR_PORTS-1:0]       writeEnable;
  logic [WR_PORTS*AW-1:0]    writeAddr;
  logic [WR_PORTS*WIDTH-1:0] writeData;
  logic                      scanStart;
  logic                      sIn;
  logic                      sOut;
  logic                      scanBusy;
  logic                      scanDone;

  modport master (
    output readAddr, writeEnable, writeAddr, writeData, scanStart, sIn,
    input  readData, sOut, scanBusy, scanDone
  );

  modport slave (
    input  readAddr, writeEnable, writeAddr, writeData, scanStart, sIn,
    output readData, sOut, scanBusy, scanDone
  );
endinterface

// File: rtl/register_file_scan_mp.sv
// Multi-port register file (N async reads, M sync writes, entry 0 reads zero) with a
// serial scan engine that shifts every entry 1..SIZE-1 out LSB-first and back in.
// Optional macro REGFILE_BYPASS_EN: same-cycle write-through forwarding to the read ports.
// Assumes WIDTH >= 2 and SIZE a power of two >= 2.
`ifndef WORD_LENGTH
`define WORD_LENGTH 32
`endif

module register_file_scan_mp #(
  parameter int unsigned SIZE     = 16,
  parameter int unsigned WIDTH    = `WORD_LENGTH,
  parameter int unsigned RD_PORTS = 3,
  parameter int unsigned WR_PORTS = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  register_file_scan_mp_if.slave bus
);
  localparam int unsigned AW = $clog2(SIZE);
  localparam int unsigned BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [2:0] {IDLE, CAPTURE, SHIFT, UPDATE, DONE} state_t;

  state_t             state, state_d;
  logic [AW-1:0]      ecnt, ecnt_d;
  logic [BW-1:0]      bcnt, bcnt_d;
  logic [WIDTH-1:0]   shreg, shreg_d;
  logic               scan_we;
  logic               busy_q, done_q, sout_q;
  logic [WIDTH-1:0]   mem [SIZE];

  // Scan FSM state, counters, shift register and registered scan outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ecnt   <= '0;
      bcnt   <= '0;
      shreg  <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sout_q <= 1'b0;
    end else begin
      state  <= state_d;
      ecnt   <= ecnt_d;
      bcnt   <= bcnt_d;
      shreg  <= shreg_d;
      busy_q <= (state_d != IDLE);
      done_q <= (state_d == DONE);
      sout_q <= (state_d == SHIFT) ? shreg_d[0] : 1'b0;
    end
  end

  // Next-state logic: capture entry, shift WIDTH bits, write the shifted word back, advance.
  always_comb begin
    state_d = state;
    ecnt_d  = ecnt;
    bcnt_d  = bcnt;
    shreg_d = shreg;
    scan_we = 1'b0;
    case (state)
      IDLE: begin
        if (bus.scanStart) begin
          ecnt_d  = AW'(1);
          state_d = CAPTURE;
        end
      end
      CAPTURE: begin
        shreg_d = mem[ecnt];
        bcnt_d  = '0;
        state_d = SHIFT;
      end
      SHIFT: begin
        shreg_d = {bus.sIn, shreg[WIDTH-1:1]};
        bcnt_d  = bcnt + BW'(1);
        if (bcnt == BW'(WIDTH - 1)) state_d = UPDATE;
      end
      UPDATE: begin
        scan_we = 1'b1;
        if (ecnt == AW'(SIZE - 1)) begin
          state_d = DONE;
        end else begin
          ecnt_d  = ecnt + AW'(1);
          state_d = CAPTURE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Storage: scan write-back has priority; functional writes blocked during a pass, port 0 wins conflicts.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(SIZE); i++) mem[i] <= '0;
    end else if (scan_we) begin
      mem[ecnt] <= shreg;
    end else if (!busy_q) begin
      for (int p = int'(WR_PORTS) - 1; p >= 0; p--) begin
        if (bus.writeEnable[p] && (bus.writeAddr[p*AW +: AW] != '0))
          mem[bus.writeAddr[p*AW +: AW]] <= bus.writeData[p*WIDTH +: WIDTH];
      end
    end
  end

  for (genvar p = 0; p < int'(RD_PORTS); p++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rd;

    assign ra = bus.readAddr[p*AW +: AW];

    // Read mux for this port; address 0 always yields zero.
    always_comb begin
      rd = (ra == '0) ? '0 : mem[ra];
`ifdef REGFILE_BYPASS_EN
      for (int q = int'(WR_PORTS) - 1; q >= 0; q--) begin
        if (!busy_q && (ra != '0) && bus.writeEnable[q] && (bus.writeAddr[q*AW +: AW] == ra))
          rd = bus.writeData[q*WIDTH +: WIDTH];
      end
`endif
    end

    assign bus.readData[p*WIDTH +: WIDTH] = rd;
  end

  assign bus.scanBusy = busy_q;
  assign bus.scanDone = done_q;
  assign bus.sOut     = sout_q;
endmodule
